// File: rtl/trng_ehr_param.sv
// trng_ehr_param: entropy holding register (EHR) for a TRNG.
// Packs CHUNK_W-bit entropy chunks into an EHR_WIDTH-bit register, lowest
// chunk first, and reports full when every chunk slot has been written. The
// CPU can read and write the register one 32-bit word at a time. A read of
// the top word while full empties the register so collection starts again.
//
// Ports
//   rng_clk, rst_n       clock, asynchronous active-low reset
//   crngt_dout/valid     CRNGT-checked chunk and its strobe
//   collector_valid      raw collector chunk strobe (data on crngt_dout)
//   trng_crngt_bypass    take collector chunks directly
//   trng_valid           TRNG already valid; blocks the bypass path
//   curr_test_err        health-test failure, synchronous clear
//   rst_trng_logic       software logic reset, synchronous clear
//   cpu_ehr_wr/rd        CPU word write / read strobes
//   cpu_word_sel         CPU word index
//   cpu_rng_pwdata       CPU write data
//   ehr_data             register contents (registered)
//   ehr_rd_data          selected word (combinational)
//   ehr_valid            register full (registered)
//   ehr_fill             chunks accepted since last clear (registered)
//   ehr_rd_collector     collector chunk consumed this cycle (combinational)
//   ehr_overflow         sticky: chunk offered while full (registered)
module trng_ehr_param #(
  parameter int unsigned EHR_WIDTH = 192,
  parameter int unsigned CHUNK_W   = 16,
  localparam int unsigned NUM_CHUNKS = EHR_WIDTH / CHUNK_W,
  localparam int unsigned NUM_WORDS  = EHR_WIDTH / 32,
  localparam int unsigned CW         = $clog2(NUM_CHUNKS + 1),
  localparam int unsigned WW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 rng_clk,
  input  logic                 rst_n,
  input  logic [CHUNK_W-1:0]   crngt_dout,
  input  logic                 crngt_valid,
  input  logic                 collector_valid,
  input  logic                 trng_crngt_bypass,
  input  logic                 trng_valid,
  input  logic                 curr_test_err,
  input  logic                 rst_trng_logic,
  input  logic                 cpu_ehr_wr,
  input  logic                 cpu_ehr_rd,
  input  logic [WW-1:0]        cpu_word_sel,
  input  logic [31:0]          cpu_rng_pwdata,
  output logic [EHR_WIDTH-1:0] ehr_data,
  output logic [31:0]          ehr_rd_data,
  output logic                 ehr_valid,
  output logic [CW-1:0]        ehr_fill,
  output logic                 ehr_rd_collector,
  output logic                 ehr_overflow
);

  localparam logic [CW-1:0] FULL_FILL = CW'(NUM_CHUNKS);
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

  logic                 bypass_ok_c;
  logic                 offer_c;
  logic                 clr_c;
  logic                 accept_c;
  logic                 rd_clear_c;
  logic                 wr_ok_c;

  logic [EHR_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]        fill_q, fill_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;

  // Event decode for this cycle
  always_comb begin
    bypass_ok_c = collector_valid & trng_crngt_bypass & ~trng_valid;
    offer_c     = crngt_valid | bypass_ok_c;
    clr_c       = curr_test_err | rst_trng_logic;
    // A CPU write owns the register this cycle, so any offered chunk is dropped
    accept_c    = offer_c & ~valid_q & ~clr_c & ~cpu_ehr_wr;
    rd_clear_c  = cpu_ehr_rd & valid_q & (cpu_word_sel == LAST_WORD);
    // Out-of-range selects match no word and are therefore ignored
    wr_ok_c     = cpu_ehr_wr & ~clr_c;
  end

  // The collector is only consumed when its chunk is the one taken
  assign ehr_rd_collector = accept_c & ~crngt_valid & bypass_ok_c;

  // Word read mux; unmatched selects return zero
  always_comb begin
    ehr_rd_data = 32'h0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (cpu_word_sel == WW'(k)) begin
        ehr_rd_data = data_q[k*32 +: 32];
      end
    end
  end

  // Next-state for contents, fill level, full flag and overflow
  always_comb begin
    data_d  = data_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    if (clr_c) begin
      data_d = '0;
      fill_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (offer_c & valid_q) begin
        ovf_d = 1'b1;
      end

      // Read-to-clear of the top word restarts collection
      if (rd_clear_c) begin
        data_d = '0;
        fill_d = '0;
      end

      if (wr_ok_c) begin
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
          if (cpu_word_sel == WW'(k)) begin
            data_d[k*32 +: 32] = cpu_rng_pwdata;
          end
        end
      end

      // accept_c implies not full, so fill_q < NUM_CHUNKS here
      if (accept_c) begin
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
          if (fill_q == CW'(i)) begin
            data_d[i*CHUNK_W +: CHUNK_W] = crngt_dout;
          end
        end
        fill_d = fill_q + CW'(1);
      end
    end

    valid_d = (fill_d == FULL_FILL);
  end

  // State registers
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ehr_data     = data_q;
  assign ehr_fill     = fill_q;
  assign ehr_valid    = valid_q;
  assign ehr_overflow = ovf_q;

endmodule

// File: tb/tb_trng_ehr_param.sv
// Bench for trng_ehr_param: directed vector table, reset corner cases, a
// 128/32 configuration, and randomized traffic against a reference model.
module tb_trng_ehr_param;

  logic         rng_clk;
  logic         rst_n;

  // Default configuration (192-bit, 16-bit chunks)
  logic [15:0]  crngt_dout;
  logic         crngt_valid, collector_valid, trng_crngt_bypass, trng_valid;
  logic         curr_test_err, rst_trng_logic, cpu_ehr_wr, cpu_ehr_rd;
  logic [2:0]   cpu_word_sel;
  logic [31:0]  cpu_rng_pwdata;
  logic [191:0] ehr_data;
  logic [31:0]  ehr_rd_data;
  logic         ehr_valid, ehr_rd_collector, ehr_overflow;
  logic [3:0]   ehr_fill;

  // Small configuration (128-bit, 32-bit chunks)
  logic [31:0]  s_dout;
  logic         s_cv;
  logic         s_idle;
  logic [1:0]   s_sel;
  logic [31:0]  s_wdata;
  logic [127:0] s_data;
  logic [31:0]  s_rd_data;
  logic         s_valid, s_rdc, s_ovf;
  logic [2:0]   s_fill;

  int checks;
  int failures;

  // Reference model state: contents, chunk count, sticky overflow
  logic [191:0] m_data;
  int           m_fill;
  logic         m_ovf;

  trng_ehr_param dut (
    .rng_clk(rng_clk), .rst_n(rst_n),
    .crngt_dout(crngt_dout), .crngt_valid(crngt_valid),
    .collector_valid(collector_valid), .trng_crngt_bypass(trng_crngt_bypass),
    .trng_valid(trng_valid), .curr_test_err(curr_test_err),
    .rst_trng_logic(rst_trng_logic), .cpu_ehr_wr(cpu_ehr_wr),
    .cpu_ehr_rd(cpu_ehr_rd), .cpu_word_sel(cpu_word_sel),
    .cpu_rng_pwdata(cpu_rng_pwdata), .ehr_data(ehr_data),
    .ehr_rd_data(ehr_rd_data), .ehr_valid(ehr_valid), .ehr_fill(ehr_fill),
    .ehr_rd_collector(ehr_rd_collector), .ehr_overflow(ehr_overflow)
  );

  trng_ehr_param #(.EHR_WIDTH(128), .CHUNK_W(32)) dut_s (
    .rng_clk(rng_clk), .rst_n(rst_n),
    .crngt_dout(s_dout), .crngt_valid(s_cv),
    .collector_valid(s_idle), .trng_crngt_bypass(s_idle),
    .trng_valid(s_idle), .curr_test_err(s_idle),
    .rst_trng_logic(s_idle), .cpu_ehr_wr(s_idle),
    .cpu_ehr_rd(s_idle), .cpu_word_sel(s_sel),
    .cpu_rng_pwdata(s_wdata), .ehr_data(s_data),
    .ehr_rd_data(s_rd_data), .ehr_valid(s_valid), .ehr_fill(s_fill),
    .ehr_rd_collector(s_rdc), .ehr_overflow(s_ovf)
  );

  initial rng_clk = 1'b0;
  always #5 rng_clk = ~rng_clk;

  typedef struct {
    logic        cv, col, byp, tv, err, rstl, wr, rd;
    logic [2:0]  sel;
    logic [31:0] wd;
    logic [15:0] dout;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic        e_rdc;
    int          e_fill;
    logic        e_valid, e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cv, logic col, logic byp, logic tv,
                              logic err, logic rstl, logic wr, logic rd,
                              logic [2:0] sel, logic [31:0] wd, logic [15:0] dout,
                              logic chk_rd, logic [31:0] e_rd, logic e_rdc,
                              int e_fill, logic e_valid, logic e_ovf);
    vec_t v;
    v.cv = cv; v.col = col; v.byp = byp; v.tv = tv; v.err = err; v.rstl = rstl;
    v.wr = wr; v.rd = rd; v.sel = sel; v.wd = wd; v.dout = dout;
    v.chk_rd = chk_rd; v.e_rd = e_rd; v.e_rdc = e_rdc;
    v.e_fill = e_fill; v.e_valid = e_valid; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    crngt_dout = '0; crngt_valid = 0; collector_valid = 0; trng_crngt_bypass = 0;
    trng_valid = 0; curr_test_err = 0; rst_trng_logic = 0; cpu_ehr_wr = 0;
    cpu_ehr_rd = 0; cpu_word_sel = '0; cpu_rng_pwdata = '0;
  endtask

  task automatic drive(input vec_t v);
    crngt_valid = v.cv; collector_valid = v.col; trng_crngt_bypass = v.byp;
    trng_valid = v.tv; curr_test_err = v.err; rst_trng_logic = v.rstl;
    cpu_ehr_wr = v.wr; cpu_ehr_rd = v.rd; cpu_word_sel = v.sel;
    cpu_rng_pwdata = v.wd; crngt_dout = v.dout;
  endtask

  task automatic model_reset();
    m_data = '0; m_fill = 0; m_ovf = 1'b0;
  endtask

  // One clock with the current inputs: checks combinational outputs before
  // the edge, advances the model, checks registered outputs after the edge.
  task automatic run_cycle();
    logic        full, offer, clr, accept, e_rdc;
    logic [31:0] e_rd;
    int          s;
    #1;
    s      = int'(cpu_word_sel);
    full   = (m_fill == 12);
    offer  = crngt_valid | (collector_valid & trng_crngt_bypass & ~trng_valid);
    clr    = curr_test_err | rst_trng_logic;
    accept = offer & ~full & ~clr & ~cpu_ehr_wr;
    // Whenever a chunk is taken without crngt_valid, it came from the collector
    e_rdc  = accept & ~crngt_valid;
    e_rd   = (s < 6) ? m_data[s*32 +: 32] : 32'h0;
    chk("rd_collector", 256'(ehr_rd_collector), 256'(e_rdc));
    chk("rd_data", 256'(ehr_rd_data), 256'(e_rd));

    if (clr) begin
      model_reset();
    end else begin
      if (offer && full) m_ovf = 1'b1;
      if (cpu_ehr_rd && s == 5 && full) begin
        m_data = '0;
        m_fill = 0;
      end
      if (cpu_ehr_wr && s < 6) m_data[s*32 +: 32] = cpu_rng_pwdata;
      if (accept) begin
        m_data[m_fill*16 +: 16] = crngt_dout;
        m_fill = m_fill + 1;
      end
    end

    @(posedge rng_clk);
    #1;
    chk("ehr_data", 256'(ehr_data), 256'(m_data));
    chk("ehr_fill", 256'(ehr_fill), 256'(m_fill));
    chk("ehr_valid", 256'(ehr_valid), 256'(m_fill == 12));
    chk("ehr_overflow", 256'(ehr_overflow), 256'(m_ovf));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    failures = 0;
    s_dout = '0; s_cv = 0; s_idle = 0; s_sel = '0; s_wdata = '0;
    idle();
    model_reset();

    // Reset state with the clock running
    rst_n = 1'b0;
    repeat (3) @(posedge rng_clk);
    #1;
    chk("rst_data", 256'(ehr_data), 256'(0));
    chk("rst_fill", 256'(ehr_fill), 256'(0));
    chk("rst_valid", 256'(ehr_valid), 256'(0));
    chk("rst_ovf", 256'(ehr_overflow), 256'(0));
    @(negedge rng_clk);
    rst_n = 1'b1;
    @(posedge rng_clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 3'd0, 32'h0, 16'(i + 1), 0, 32'h0, 0,
                       i + 1, (i == 11), 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 3'd0, 32'h0, 16'h000D, 0, 32'h0, 0, 12, 1, 1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 3'd5, 32'h0, 16'h0, 1, 32'h000C000B, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0,0,0,0, 3'd0, 32'h0, 16'(16'hA0 + i), 0, 32'h0, 1,
                       i + 1, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,1,0,0,0,0, 3'd0, 32'h0, 16'(16'hB0 + i), 0, 32'h0, 0,
                       3, 0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 3'd0, 32'h0, 16'h0100, 0, 32'h0, 0, 4, 0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 3'd0, 32'h0, 16'h0101, 0, 32'h0, 0, 5, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,0,0, 3'd0, 32'h0, 16'h0102, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,1,0, 3'd2, 32'hDEADBEEF, 16'h0055, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1, 3'd7, 32'h12345678, 16'h0, 1, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 3'd2, 32'h0, 16'h0, 1, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,1,0,0,1,0,0, 3'd0, 32'h0, 16'h0077, 0, 32'h0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v);
      #1;
      chk("tbl_rd_collector", 256'(ehr_rd_collector), 256'(v.e_rdc));
      if (v.chk_rd) chk("tbl_rd_data", 256'(ehr_rd_data), 256'(v.e_rd));
      run_cycle();
      chk("tbl_fill", 256'(ehr_fill), 256'(v.e_fill));
      chk("tbl_valid", 256'(ehr_valid), 256'(v.e_valid));
      chk("tbl_ovf", 256'(ehr_overflow), 256'(v.e_ovf));
      if (i == 11) begin
        chk("full_low_chunk", 256'(ehr_data[15:0]), 256'(16'h0001));
        chk("full_high_chunk", 256'(ehr_data[191:176]), 256'(16'h000C));
      end
      if (i == 23) chk("cpu_word2", 256'(ehr_data[95:64]), 256'(32'hDEADBEEF));
    end
    idle();

    // Asynchronous reset in the middle of a cycle at fill 7
    for (int i = 0; i < 7; i++) begin
      crngt_valid = 1'b1;
      crngt_dout = 16'($urandom);
      run_cycle();
    end
    chk("pre_reset_fill", 256'(ehr_fill), 256'(7));
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data", 256'(ehr_data), 256'(0));
    chk("async_fill", 256'(ehr_fill), 256'(0));
    chk("async_valid", 256'(ehr_valid), 256'(0));
    chk("async_ovf", 256'(ehr_overflow), 256'(0));
    model_reset();
    @(negedge rng_clk);
    rst_n = 1'b1;
    @(posedge rng_clk);
    #1;
    crngt_valid = 1'b1;
    crngt_dout = 16'h5A5A;
    run_cycle();
    chk("restart_chunk0", 256'(ehr_data[15:0]), 256'(16'h5A5A));
    idle();

    // 128-bit / 32-bit configuration fills after four chunks
    for (int k = 0; k < 4; k++) begin
      s_cv = 1'b1;
      s_dout = 32'h1111_0000 + 32'(k);
      @(posedge rng_clk);
      #1;
      chk("small_fill", 256'(s_fill), 256'(k + 1));
      chk("small_valid", 256'(s_valid), 256'(k == 3));
    end
    s_cv = 1'b0;
    chk("small_data", 256'(s_data),
        256'({32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      crngt_valid       = ($urandom % 3) == 0;
      collector_valid   = 1'($urandom);
      trng_crngt_bypass = 1'($urandom);
      trng_valid        = ($urandom % 4) == 0;
      curr_test_err     = ($urandom % 64) == 0;
      rst_trng_logic    = ($urandom % 64) == 0;
      cpu_ehr_wr        = ($urandom % 12) == 0;
      cpu_ehr_rd        = ($urandom % 4) == 0;
      cpu_word_sel      = (($urandom % 2) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      cpu_rng_pwdata    = $urandom;
      crngt_dout        = 16'($urandom);
      run_cycle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trng_ehr_param.md
TRNG_EHR_PARAM -- requirements
Module: trng_ehr_param

Interface
REQ-001 SHALL have parameter EHR_WIDTH, default 192: holding-register width in bits; a multiple of 32 and of CHUNK_W.
REQ-002 SHALL have parameter CHUNK_W, default 16: width of one entropy chunk; one of 8, 16 or 32.
REQ-003 SHALL derive NUM_CHUNKS = EHR_WIDTH/CHUNK_W, NUM_WORDS = EHR_WIDTH/32, CW = clog2(NUM_CHUNKS+1) and WW = clog2(NUM_WORDS).
REQ-004 SHALL have ports:
- rng_clk  in  1  sole clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- crngt_dout  in  CHUNK_W  CRNGT-checked chunk.
- crngt_valid  in  1  crngt_dout valid this cycle.
- collector_valid  in  1  raw collector chunk valid; data on crngt_dout.
- trng_crngt_bypass  in  1  accept collector chunks directly.
- trng_valid  in  1  TRNG already valid; blocks the bypass path.
- curr_test_err  in  1  health-test failure; synchronous clear.
- rst_trng_logic  in  1  software logic reset; synchronous clear.
- cpu_ehr_wr  in  1  CPU word write strobe.
- cpu_ehr_rd  in  1  CPU word read strobe.
- cpu_word_sel  in  WW  CPU word index; word k = bits [32k+31:32k].
- cpu_rng_pwdata  in  32  CPU write data.
- ehr_data  out  EHR_WIDTH  holding-register contents.
- ehr_rd_data  out  32  combinational word selected by cpu_word_sel.
- ehr_valid  out  1  register full.
- ehr_fill  out  CW  chunks accepted since the last clear.
- ehr_rd_collector  out  1  collector chunk consumed this cycle.
- ehr_overflow  out  1  sticky flag: chunk offered while full.

Function
REQ-005 SHALL define offer = crngt_valid | (collector_valid & trng_crngt_bypass & ~trng_valid).
REQ-006 SHALL define clr = curr_test_err | rst_trng_logic.
REQ-007 SHALL define accept = offer & ~ehr_valid & ~clr & ~cpu_ehr_wr.
REQ-008 On accept, SHALL write crngt_dout to bits [CHUNK_W*(f+1)-1 : CHUNK_W*f], where f = ehr_fill, and increment ehr_fill by 1 on the same edge.
REQ-009 SHALL drive ehr_valid=1 exactly when ehr_fill = NUM_CHUNKS; ehr_fill SHALL never exceed NUM_CHUNKS or wrap.
REQ-010 SHALL drive ehr_rd_collector = accept & ~crngt_valid & collector_valid & trng_crngt_bypass & ~trng_valid (combinational).
REQ-011 When clr=1, SHALL on that edge zero ehr_data, ehr_fill and ehr_overflow; clr has top priority over every other event.
REQ-012 When cpu_ehr_wr=1 and clr=0, SHALL write cpu_rng_pwdata to word cpu_word_sel.
REQ-013 A CPU write SHALL NOT change ehr_fill or ehr_valid.
REQ-014 A chunk offered in the same cycle as a CPU write SHALL be dropped without setting ehr_overflow.
REQ-015 An out-of-range cpu_word_sel (>= NUM_WORDS) on write SHALL be ignored.
REQ-016 An out-of-range cpu_word_sel on read SHALL make ehr_rd_data return 0.
REQ-017 A read of word NUM_WORDS-1 with cpu_ehr_rd=1 while ehr_valid=1 SHALL, on that edge, zero ehr_data and ehr_fill so collection restarts; ehr_rd_data SHALL still present the pre-clear word in that cycle.
REQ-018 ehr_overflow SHALL set on any edge where offer & ehr_valid & ~clr, and SHALL stay set until clr or reset.
REQ-019 Simultaneous read-to-clear (REQ-017) and offer SHALL clear the register; the chunk is not accepted and ehr_overflow is set.
REQ-020 Write data SHALL become visible on ehr_data one cycle after the accepting edge; ehr_data is registered with no further pipeline.

Reset
REQ-021 While rst_n=0, SHALL hold ehr_data=0, ehr_fill=0, ehr_valid=0 and ehr_overflow=0, independent of rng_clk.
REQ-022 Reset mid-fill SHALL discard partial contents; collection restarts at chunk 0 after rst_n rises.

Verification
REQ-023 Defaults, 12 crngt_valid pulses with crngt_dout=16'h0001..16'h000C -> ehr_valid=1, ehr_fill=12, ehr_data[15:0]=16'h0001, ehr_data[191:176]=16'h000C.
REQ-024 When full, a 13th pulse -> ehr_data unchanged, ehr_overflow=1; then read word 5 -> ehr_rd_data=32'h000C000B, next cycle ehr_fill=0, ehr_valid=0, ehr_overflow still 1.
REQ-025 With bypass=1, trng_valid=0 and collector_valid=1 for 3 cycles -> ehr_rd_collector high for 3 cycles, ehr_fill=3; repeat with trng_valid=1 -> no accept and ehr_rd_collector=0.
REQ-026 At fill=5, curr_test_err=1 together with crngt_valid=1 -> next cycle ehr_data=0, ehr_fill=0, ehr_overflow=0.
REQ-027 CPU write of 32'hDEADBEEF to word 2 in the same cycle as crngt_valid -> ehr_data[95:64]=32'hDEADBEEF, ehr_fill unchanged, ehr_overflow=0.
REQ-028 Assert rst_n=0 asynchronously mid-cycle at fill=7 -> all outputs 0 immediately; rerun with EHR_WIDTH=128 and CHUNK_W=32 -> ehr_valid after 4 chunks.
